// File: rtl/gray_sequence_checker.sv
// Receive-side monitor for a Gray-coded counter: decodes the sampled word, classifies
// each transition as up/down/illegal and tracks lock, stall and error status.
//
// state     | meaning
// ACQUIRE   | counting consecutive legal up-steps towards lock
// TRACK     | locked; any down-step or illegal jump is an error
// ERROR     | one-cycle error report, then back to ACQUIRE
module gray_sequence_checker #(
  parameter int N          = 4,
  parameter int LOCK_STEPS = 4,
  parameter int TIMEOUT    = 2048,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     gray_in,
  output logic [N-1:0]     bin_out,
  output logic             bin_valid,
  output logic             step_up,
  output logic             step_down,
  output logic             locked,
  output logic             stall,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [N-1:0]      ONE       = N'(1);
  localparam logic [3:0]        STEP_LAST = 4'(LOCK_STEPS - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

  typedef enum logic [1:0] {S_ACQUIRE, S_TRACK, S_ERROR} state_t;

  state_t            state, state_nx;
  logic [N-1:0]      g_q, prev, dec_cur, diff;
  logic              g_valid;
  logic [3:0]        step_cnt, step_nx;
  logic [IDLE_W-1:0] idle_cnt, idle_nx;
  logic              cls_valid, changed, single, is_up, is_down, is_bad;

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // bin_out always holds the decode of prev, so it doubles as the previous binary value
  assign dec_cur   = gray2bin(g_q);
  assign diff      = g_q ^ prev;
  assign cls_valid = g_valid & bin_valid;
  assign changed   = cls_valid && (diff != '0);
  assign single    = (diff & (diff - ONE)) == '0;
  assign is_up     = changed && single && (dec_cur == bin_out + ONE);
  assign is_down   = changed && single && (dec_cur == bin_out - ONE);
  // a single-bit flip that is not an adjacent code is as illegal as a multi-bit jump
  assign is_bad    = changed && !is_up && !is_down;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g_q       <= '0;
      g_valid   <= 1'b0;
      prev      <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
    end else begin
      g_q       <= gray_in;
      g_valid   <= 1'b1;
      prev      <= g_q;
      bin_out   <= dec_cur;
      bin_valid <= bin_valid | g_valid;
      step_up   <= is_up;
      step_down <= is_down;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_ACQUIRE;
      step_cnt  <= '0;
      idle_cnt  <= '0;
      err_count <= '0;
    end else begin
      state    <= state_nx;
      step_cnt <= step_nx;
      idle_cnt <= idle_nx;
      if (state_nx == S_ERROR && err_count != '1) err_count <= err_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    step_nx  = step_cnt;
    idle_nx  = idle_cnt;
    case (state)
      S_ACQUIRE: begin
        if (is_up) begin
          if (step_cnt == STEP_LAST) begin
            state_nx = S_TRACK;
            step_nx  = '0;
          end else begin
            step_nx = step_cnt + 4'd1;
          end
        end else if (is_down || is_bad) begin
          step_nx = '0;
        end
      end
      S_TRACK: begin
        if (is_down || is_bad) begin
          state_nx = S_ERROR;
          idle_nx  = '0;
        end else if (changed) begin
          idle_nx = '0;
        end else if (cls_valid && idle_cnt != IDLE_MAX) begin
          idle_nx = idle_cnt + IDLE_W'(1);
        end
      end
      S_ERROR: begin
        state_nx = S_ACQUIRE;
        step_nx  = '0;
        idle_nx  = '0;
      end
      default: state_nx = S_ACQUIRE;
    endcase
  end

  assign locked    = (state == S_TRACK);
  assign stall     = locked && (idle_cnt == IDLE_MAX);
  assign err_pulse = (state == S_ERROR);

endmodule

// File: tb/tb_gray_sequence_checker.sv
// Bench for gray_sequence_checker: directed Gray sequences, a cycle-by-cycle reference
// model built from the transition rules, and literal checkpoints along the way.
module tb_gray_sequence_checker;

  localparam int N          = 4;
  localparam int LOCK_STEPS = 4;
  localparam int TIMEOUT    = 2048;
  localparam int CNT_W      = 2;
  localparam int MODN       = 1 << N;
  localparam int ERR_MAX    = (1 << CNT_W) - 1;
  localparam int M_ACQ = 0, M_TRK = 1, M_ERR = 2;
  localparam int C_NONE = 0, C_UP = 1, C_DOWN = 2, C_BAD = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     gray_in;
  logic [N-1:0]     bin_out;
  logic             bin_valid, step_up, step_down, locked, stall, err_pulse;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;
  int n_up = 0, n_err = 0, n_both = 0;
  int cur_bin = 0;

  // reference model state: sampled codes (-1 = none yet), mode, counters
  int m_cur = -1, m_prev = -1;
  int m_mode = 0, m_steps = 0, m_idle = 0, m_errs = 0;
  int exp_bin = 0, exp_valid = 0, exp_up = 0, exp_down = 0;

  logic [N-1:0] wrap_codes [12] = '{4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111,
                                    4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

  gray_sequence_checker #(.N(N), .LOCK_STEPS(LOCK_STEPS), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .gray_in(gray_in), .bin_out(bin_out), .bin_valid(bin_valid),
    .step_up(step_up), .step_down(step_down), .locked(locked), .stall(stall),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic int g2b(input int g);
    int b = 0;
    for (int s = 0; s < N; s++) b = b ^ (g >> s);
    return b & (MODN - 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic put(input logic [N-1:0] g, input int n);
    gray_in = g;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_bin(input int b, input int n);
    cur_bin = b % MODN;
    put(N'(cur_bin ^ (cur_bin >> 1)), n);
  endtask

  always @(posedge clk or negedge reset) begin : model
    int cls, dc, dp;
    if (!reset) begin
      m_cur <= -1; m_prev <= -1;
      m_mode <= M_ACQ; m_steps <= 0; m_idle <= 0; m_errs <= 0;
      exp_bin <= 0; exp_valid <= 0; exp_up <= 0; exp_down <= 0;
    end else begin
      cls = C_NONE;
      if (m_cur >= 0 && m_prev >= 0 && m_cur != m_prev) begin
        dc = g2b(m_cur);
        dp = g2b(m_prev);
        if ($countones(m_cur ^ m_prev) == 1 && (dc - dp + MODN) % MODN == 1) cls = C_UP;
        else if ($countones(m_cur ^ m_prev) == 1 && (dp - dc + MODN) % MODN == 1) cls = C_DOWN;
        else cls = C_BAD;
      end
      exp_up   <= (cls == C_UP) ? 1 : 0;
      exp_down <= (cls == C_DOWN) ? 1 : 0;
      exp_bin  <= (m_cur >= 0) ? g2b(m_cur) : 0;
      if (m_cur >= 0) exp_valid <= 1;
      case (m_mode)
        M_ACQ: begin
          if (cls == C_UP) begin
            if (m_steps + 1 == LOCK_STEPS) begin m_mode <= M_TRK; m_steps <= 0; end
            else m_steps <= m_steps + 1;
          end else if (cls != C_NONE) m_steps <= 0;
        end
        M_TRK: begin
          if (cls == C_DOWN || cls == C_BAD) begin
            m_mode <= M_ERR; m_idle <= 0;
            m_errs <= (m_errs < ERR_MAX) ? m_errs + 1 : ERR_MAX;
          end else if (cls == C_UP) m_idle <= 0;
          else if (m_idle < TIMEOUT) m_idle <= m_idle + 1;
        end
        default: begin m_mode <= M_ACQ; m_steps <= 0; m_idle <= 0; end
      endcase
      m_prev <= m_cur;
      m_cur  <= int'(gray_in);
    end
  end

  always @(negedge clk) begin
    chk("bin_out",   32'(bin_out),   32'(exp_bin));
    chk("bin_valid", 32'(bin_valid), 32'(exp_valid));
    chk("step_up",   32'(step_up),   32'(exp_up));
    chk("step_down", 32'(step_down), 32'(exp_down));
    chk("locked",    32'(locked),    (m_mode == M_TRK) ? 32'd1 : 32'd0);
    chk("stall",     32'(stall),     (m_mode == M_TRK && m_idle == TIMEOUT) ? 32'd1 : 32'd0);
    chk("err_pulse", 32'(err_pulse), (m_mode == M_ERR) ? 32'd1 : 32'd0);
    chk("err_count", 32'(err_count), 32'(m_errs));
    if (step_up) n_up++;
    if (err_pulse) n_err++;
    if (step_down && err_pulse) n_both++;
  end

  initial begin
    gray_in = 4'b0110;
    reset   = 1'b1;
    #2 reset = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_bin", 32'(bin_out), 0);
    chk("rst_valid", 32'(bin_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rel_bin", 32'(bin_out), 4);
    chk("rel_valid", 32'(bin_valid), 1);
    @(posedge clk); #1;

    n_up = 0;
    put(4'b0000, 10); put(4'b0001, 10); put(4'b0011, 10); put(4'b0010, 10); put(4'b0110, 10);
    chk("count_steps", n_up, 4);
    chk("count_locked", 32'(locked), 1);
    chk("count_errs", 32'(err_count), 0);

    n_up = 0; n_err = 0;
    for (int i = 0; i < 12; i++) put(wrap_codes[i], 3);
    chk("wrap_steps", n_up, 12);
    chk("wrap_locked", 32'(locked), 1);
    chk("wrap_no_err", n_err, 0);
    chk("wrap_bin", 32'(bin_out), 0);

    put(4'b0001, 3); put(4'b0011, 3); put(4'b0010, 3);
    chk("jump_pre_lock", 32'(locked), 1);
    n_err = 0;
    put(4'b0101, 3);
    chk("jump_pulses", n_err, 1);
    chk("jump_count", 32'(err_count), 1);
    chk("jump_unlock", 32'(locked), 0);
    put(4'b0100, 3); put(4'b1100, 3); put(4'b1101, 3); put(4'b1111, 3);
    chk("jump_relock", 32'(locked), 1);

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_count", 32'(err_count), 0);
    chk("mid_rst_valid", 32'(bin_valid), 0);
    chk("mid_rst_locked", 32'(locked), 0);
    reset = 1'b1;
    put(4'b0000, 5); put(4'b0001, 5); put(4'b0011, 5); put(4'b0010, 5); put(4'b0110, 5);
    chk("down_pre_lock", 32'(locked), 1);
    n_both = 0;
    put(4'b0010, 4);
    chk("down_with_err", n_both, 1);
    chk("down_count", 32'(err_count), 1);
    chk("down_unlock", 32'(locked), 0);

    put(4'b0110, 3); put(4'b0111, 3); put(4'b0101, 3); put(4'b0100, 3);
    chk("stall_pre_lock", 32'(locked), 1);
    put(4'b0100, TIMEOUT + 3);
    chk("stall_on", 32'(stall), 1);
    put(4'b1100, 2);
    chk("stall_clear", 32'(stall), 0);
    chk("stall_locked", 32'(locked), 1);
    put(4'b1100, TIMEOUT + 2);
    chk("stall_on2", 32'(stall), 1);
    n_err = 0;
    put(4'b0000, 3);
    chk("stall_viol_err", n_err, 1);
    chk("stall_viol_count", 32'(err_count), 2);
    chk("stall_viol_stall", 32'(stall), 0);

    cur_bin = 0;
    for (int i = 0; i < 4; i++) put_bin(cur_bin + 1, 2);
    chk("sat_pre_lock", 32'(locked), 1);
    for (int k = 0; k < 5; k++) begin
      put_bin(cur_bin + 8, 1);
      for (int j = 0; j < 5; j++) put_bin(cur_bin + 1, 2);
      chk("sat_relock", 32'(locked), 1);
    end
    chk("sat_count", 32'(err_count), 3);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
